// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read port between pc_fetch_unit (master) and the memory (slave).
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_valid);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_valid);
endinterface

// File: rtl/pc_fetch_unit.sv
// PC / fetch control: IDLE -> FETCH (wait imem_valid) -> HOLD (wait commit) -> FETCH.
// Optional macro MISALIGN_TRAP_EN: a misaligned Jr target parks the block in TRAP until reset.
module pc_fetch_unit (
  input  logic                  clock,
  input  logic                  reset,
  pc_fetch_unit_if.master       imem,
  output logic [31:0]           Instruction,
  output logic                  instr_valid,
  input  logic                  commit,
  input  logic [31:0]           Addr_Result,
  input  logic                  Zero,
  input  logic [31:0]           Read_data_1,
  input  logic                  Branch,
  input  logic                  nBranch,
  input  logic                  Jmp,
  input  logic                  Jal,
  input  logic                  Jr,
  output logic [31:0]           pc,
  output logic [31:0]           PC_plus_4,
  output logic [31:0]           link_addr,
  output logic                  trap
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] TRAP  = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_pc, r_instr, r_link;
  logic [31:0] w_pc_plus_4, w_next_pc, w_jr_tgt;
  logic        w_taken, w_misalign;

  assign w_pc_plus_4 = r_pc + 32'd4;

`ifdef MISALIGN_TRAP_EN
  assign w_jr_tgt   = Read_data_1;
  assign w_misalign = Jr & (|Read_data_1[1:0]);
  assign trap       = (r_state == TRAP);
`else
  assign w_jr_tgt   = {Read_data_1[31:2], 2'b00};
  assign w_misalign = 1'b0;
  assign trap       = 1'b0;
`endif

  // Upper Addr_Result bits are dropped by the word-to-byte shift.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, Addr_Result[31:30]};

  // Next-PC selection: Jr beats Jmp/Jal beats a taken branch beats sequential.
  always_comb begin
    w_taken   = (Branch & Zero) | (nBranch & ~Zero);
    w_next_pc = w_pc_plus_4;
    if (Jr)              w_next_pc = w_jr_tgt;
    else if (Jmp | Jal)  w_next_pc = {w_pc_plus_4[31:28], r_instr[25:0], 2'b00};
    else if (w_taken)    w_next_pc = {Addr_Result[29:0], 2'b00};
  end

  // Fetch FSM plus PC, instruction and link registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pc    <= 32'h0;
      r_instr <= 32'h0;
      r_link  <= 32'h0;
    end else begin
      case (r_state)
        IDLE:  r_state <= FETCH;
        FETCH: if (imem.imem_valid) begin
                 r_instr <= imem.imem_rdata;
                 r_state <= HOLD;
               end
        HOLD:  if (commit) begin
                 if (Jal) r_link <= w_pc_plus_4;
                 if (w_misalign) r_state <= TRAP;
                 else begin
                   r_pc    <= w_next_pc;
                   r_state <= FETCH;
                 end
               end
        TRAP:  r_state <= TRAP;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem.imem_req  = (r_state == FETCH);
  assign imem.imem_addr = r_pc[15:2];
  assign instr_valid    = (r_state == HOLD);
  assign Instruction    = r_instr;
  assign pc             = r_pc;
  assign PC_plus_4      = w_pc_plus_4;
  assign link_addr      = r_link;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: vector table of fetch+commit steps plus reset/trap corners.
module tb_pc_fetch_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] Instruction, pc, PC_plus_4, link_addr;
  logic        instr_valid, trap;
  logic        commit, Zero, Branch, nBranch, Jmp, Jal, Jr;
  logic [31:0] Addr_Result, Read_data_1;

  pc_fetch_unit_if u_if();

  pc_fetch_unit dut (
    .clock(clock), .reset(reset), .imem(u_if),
    .Instruction(Instruction), .instr_valid(instr_valid), .commit(commit),
    .Addr_Result(Addr_Result), .Zero(Zero), .Read_data_1(Read_data_1),
    .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr),
    .pc(pc), .PC_plus_4(PC_plus_4), .link_addr(link_addr), .trap(trap)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  ctl;      // {Branch, nBranch, Zero, Jmp, Jal, Jr}
    logic [31:0] ar, rd1, exp_pc, exp_link;
    int          lat;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(logic [31:0] instr, logic [5:0] ctl, logic [31:0] ar,
                              logic [31:0] rd1, logic [31:0] exp_pc, logic [31:0] exp_link, int lat);
    vec_t v;
    v.instr = instr; v.ctl = ctl; v.ar = ar; v.rd1 = rd1;
    v.exp_pc = exp_pc; v.exp_link = exp_link; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clr_ctl();
    commit = 0; Branch = 0; nBranch = 0; Zero = 0; Jmp = 0; Jal = 0; Jr = 0;
    Addr_Result = 32'h0; Read_data_1 = 32'h0;
  endtask

  // Serve one fetch: wait for the request, check address, return data after lat cycles.
  task automatic do_fetch(input string nm, input logic [31:0] data, input int lat,
                          input logic [31:0] cur_pc);
    int n = 0;
    while (!u_if.imem_req && n < 20) begin @(posedge clock); #1; n++; end
    chk({nm, "_req"}, {31'b0, u_if.imem_req}, 32'd1);
    chk({nm, "_addr"}, {18'b0, u_if.imem_addr}, {18'b0, cur_pc[15:2]});
    for (int i = 1; i < lat; i++) begin
      @(posedge clock); #1;
      chk({nm, "_addr_stable"}, {18'b0, u_if.imem_addr}, {18'b0, cur_pc[15:2]});
    end
    u_if.imem_rdata = data; u_if.imem_valid = 1;
    @(posedge clock); #1;
    u_if.imem_valid = 0; u_if.imem_rdata = 32'hDEADBEEF;
    chk({nm, "_instr"}, Instruction, data);
    chk({nm, "_ivalid"}, {31'b0, instr_valid}, 32'd1);
    chk({nm, "_req_hold"}, {31'b0, u_if.imem_req}, 32'd0);
    chk({nm, "_pc4"}, PC_plus_4, cur_pc + 32'd4);
  endtask

  task automatic do_commit(input string nm, input vec_t v);
    {Branch, nBranch, Zero, Jmp, Jal, Jr} = v.ctl;
    Addr_Result = v.ar; Read_data_1 = v.rd1; commit = 1;
    @(posedge clock); #1;
    clr_ctl();
    chk({nm, "_pc"}, pc, v.exp_pc);
    chk({nm, "_link"}, link_addr, v.exp_link);
    chk({nm, "_newreq"}, {31'b0, u_if.imem_req}, 32'd1);
    chk({nm, "_ivalid0"}, {31'b0, instr_valid}, 32'd0);
  endtask

  logic [31:0] cur_pc;

  initial begin
    vt[0]  = mk(32'h00000000, 6'b000001, 32'h0,        32'h00000010, 32'h00000010, 32'h0,  2);
    vt[1]  = mk(32'h10000002, 6'b101000, 32'h8,        32'h0,        32'h00000020, 32'h0,  1);
    vt[2]  = mk(32'h00000000, 6'b000001, 32'h0,        32'h00000010, 32'h00000010, 32'h0,  3);
    vt[3]  = mk(32'h10000002, 6'b100000, 32'h8,        32'h0,        32'h00000014, 32'h0,  1);
    vt[4]  = mk(32'h14000000, 6'b010000, 32'h40,       32'h0,        32'h00000100, 32'h0,  2);
    vt[5]  = mk(32'h14000000, 6'b011000, 32'h40,       32'h0,        32'h00000104, 32'h0,  1);
    vt[6]  = mk(32'h00000000, 6'b000001, 32'h0,        32'h00000040, 32'h00000040, 32'h0,  1);
    vt[7]  = mk(32'h0C000100, 6'b000010, 32'h0,        32'h0,        32'h00000400, 32'h44, 2);
    vt[8]  = mk(32'h08000020, 6'b000100, 32'h0,        32'h0,        32'h00000080, 32'h44, 1);
    vt[9]  = mk(32'h0C000100, 6'b101011, 32'h8,        32'h00000200, 32'h00000200, 32'h84, 3);
    vt[10] = mk(32'h08000020, 6'b101100, 32'h3,        32'h0,        32'h00000080, 32'h84, 1);
    vt[11] = mk(32'h00000000, 6'b000001, 32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 32'h84, 1);
    vt[12] = mk(32'h00000000, 6'b000000, 32'h0,        32'h0,        32'h00000000, 32'h84, 2);
    vt[13] = mk(32'h10000002, 6'b101000, 32'hC0000010, 32'h0,        32'h00000040, 32'h84, 1);
    vt[14] = mk(32'h00000000, 6'b000001, 32'h0,        32'h70000000, 32'h70000000, 32'h84, 1);
    vt[15] = mk(32'h08000004, 6'b000100, 32'h0,        32'h0,        32'h70000010, 32'h84, 2);
    vt[16] = mk(32'h00000000, 6'b000001, 32'h0,        32'h00000040, 32'h00000040, 32'h84, 1);

    clr_ctl();
    u_if.imem_valid = 0; u_if.imem_rdata = 32'h0;
    reset = 0;
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_link", link_addr, 32'h0);
    chk("rst_req", {31'b0, u_if.imem_req}, 32'd0);
    chk("rst_ivalid", {31'b0, instr_valid}, 32'd0);
    chk("rst_trap", {31'b0, trap}, 32'd0);

    repeat (2) @(posedge clock);
    #1 reset = 1;
    chk("idle_req", {31'b0, u_if.imem_req}, 32'd0);
    @(posedge clock); #1;
    chk("first_req", {31'b0, u_if.imem_req}, 32'd1);
    chk("first_addr", {18'b0, u_if.imem_addr}, 32'd0);
    cur_pc = 32'h0;
    do_fetch("boot", 32'h20080005, 3, cur_pc);

    // Vector table: each step fetches a word at the current PC then commits.
    for (int i = 0; i < 17; i++) begin
      if (i != 0) do_fetch($sformatf("v%0d_f", i), vt[i].instr, vt[i].lat, cur_pc);
      else begin
        // boot fetch already done at pc 0
      end
      do_commit($sformatf("v%0d", i), vt[i]);
      cur_pc = vt[i].exp_pc;
    end

    // commit alone in FETCH is ignored
    commit = 1; Jr = 1; Read_data_1 = 32'h500;
    @(posedge clock); #1;
    clr_ctl();
    chk("fcommit_pc", pc, 32'h40);
    chk("fcommit_req", {31'b0, u_if.imem_req}, 32'd1);

    // commit together with imem_valid in FETCH: data latched, commit ignored
    commit = 1; Jr = 1; Read_data_1 = 32'h500;
    u_if.imem_valid = 1; u_if.imem_rdata = 32'h0C000100;
    @(posedge clock); #1;
    clr_ctl(); u_if.imem_valid = 0;
    chk("fboth_pc", pc, 32'h40);
    chk("fboth_instr", Instruction, 32'h0C000100);
    chk("fboth_ivalid", {31'b0, instr_valid}, 32'd1);

    // misaligned Jr
    commit = 1; Jr = 1; Read_data_1 = 32'h00000102;
    @(posedge clock); #1;
    clr_ctl();
`ifdef MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      chk("trap_flag", {31'b0, trap}, 32'd1);
      chk("trap_pc", pc, 32'h40);
      chk("trap_req", {31'b0, u_if.imem_req}, 32'd0);
      @(posedge clock); #1;
    end
`else
    chk("jr_mis_pc", pc, 32'h00000100);
    chk("jr_mis_trap", {31'b0, trap}, 32'd0);
    chk("jr_mis_req", {31'b0, u_if.imem_req}, 32'd1);
`endif

    // Reset from wherever we are, then abort a pending fetch mid-wait.
    for (int k = 0; k < 2; k++) begin
      reset = 0;
      #2;
      chk("abort_pc", pc, 32'h0);
      chk("abort_link", link_addr, 32'h0);
      chk("abort_req", {31'b0, u_if.imem_req}, 32'd0);
      chk("abort_trap", {31'b0, trap}, 32'd0);
      @(posedge clock); #1;
      reset = 1;
      u_if.imem_valid = 1; u_if.imem_rdata = 32'hCAFEF00D;
      @(posedge clock); #1;
      u_if.imem_valid = 0;
      chk("late_instr", Instruction, 32'h0);
      chk("late_ivalid", {31'b0, instr_valid}, 32'd0);
      chk("late_req", {31'b0, u_if.imem_req}, 32'd1);
      chk("late_addr", {18'b0, u_if.imem_addr}, 32'd0);
      @(posedge clock); #1;
    end

    do_fetch("post", 32'h11111111, 1, 32'h0);
    do_commit("post", mk(32'h0, 6'b000000, 32'h0, 32'h0, 32'h4, 32'h0, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
